// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared definitions for the tick scheduler: command encoding, channel state
// encoding, default widths and a small helper that decides whether a channel
// state counts toward the busy flag.
//
// Optional build macro: TICK_SCHED_PHASE_ALIGN_EN
//   When defined, a START from IDLE parks the channel in ARMED until the next
//   base tick. ARMED channels are reported as active.
// -----------------------------------------------------------------------------
package tick_sched_pkg;

  localparam int NCH_DEF     = 2;
  localparam int PRE_W_DEF   = 26;
  localparam int PRE_MAX_DEF = 49999;
  localparam int DIV_W_DEF   = 8;

  localparam logic [1:0] CMD_SET_DIV = 2'b00;
  localparam logic [1:0] CMD_START   = 2'b01;
  localparam logic [1:0] CMD_PAUSE   = 2'b10;
  localparam logic [1:0] CMD_STOP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ARMED = 2'd3
  } chan_st_e;

  // A channel is "active" when it will react to the next base tick.
  function automatic logic is_active(chan_st_e st);
`ifdef TICK_SCHED_PHASE_ALIGN_EN
    return (st == ST_RUN) || (st == ST_ARMED);
`else
    return (st == ST_RUN);
`endif
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// -----------------------------------------------------------------------------
// tick_sched_if
// Command port of the tick scheduler (valid/ready handshake plus error pulse).
//
// Signals:
//   cfg_valid  master->slave  command valid
//   cfg_ready  slave->master  command accepted when valid && ready at posedge
//   cfg_ch     master->slave  target channel index
//   cfg_cmd    master->slave  00 SET_DIV, 01 START, 10 PAUSE, 11 STOP
//   cfg_div    master->slave  divisor for SET_DIV
//   cfg_err    slave->master  one-cycle pulse on accepted out-of-range channel
// -----------------------------------------------------------------------------
interface tick_sched_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_cmd;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_cmd,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_cmd,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/tick_sched_chan.sv
// -----------------------------------------------------------------------------
// tick_chan
// One divider channel of the tick scheduler: FSM, count, divisor register and
// registered tick/wave outputs.
//
// Optional build macro: TICK_SCHED_PHASE_ALIGN_EN (adds the ARMED state).
//
// State table:
//   state    | meaning
//   ST_IDLE  | stopped, count = 0, wave = 0
//   ST_RUN   | counting base ticks
//   ST_HOLD  | paused, count and wave frozen
//   ST_ARMED | started, waiting for the next base tick (phase-align build only)
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   base_tick_i  shared prescaler terminal-count pulse
//   cmd_stb_i    accepted command addressed to this channel
//   cmd_i        command code
//   div_i        divisor for SET_DIV
//   tick_o       one-cycle enable, registered
//   wave_o       square wave, registered
//   active_o     channel contributes to busy
// -----------------------------------------------------------------------------
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             base_tick_i,
  input  logic             cmd_stb_i,
  input  logic [1:0]       cmd_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             wave_o,
  output logic             active_o
);

  chan_st_e         state_q;
  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  logic             wave_q;

  logic [DIV_W-1:0] last_cnt;
  logic             at_term;

  // A divisor of 0 behaves as 1, so the last count is 0 in both cases.
  assign last_cnt = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign at_term  = (count_q == last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      wave_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      // A command always wins over a base tick landing in the same cycle.
      if (cmd_stb_i) begin
        case (cmd_i)
          CMD_SET_DIV: begin
            div_q   <= div_i;
            count_q <= '0;
          end
          CMD_START: begin
            case (state_q)
`ifdef TICK_SCHED_PHASE_ALIGN_EN
              ST_IDLE: state_q <= ST_ARMED;
`else
              ST_IDLE: state_q <= ST_RUN;
`endif
              ST_HOLD: state_q <= ST_RUN;
              default: ;
            endcase
          end
          CMD_PAUSE: begin
            case (state_q)
              ST_RUN:   state_q <= ST_HOLD;
`ifdef TICK_SCHED_PHASE_ALIGN_EN
              // Never counted yet, so dropping back to IDLE loses nothing.
              ST_ARMED: state_q <= ST_IDLE;
`endif
              default: ;
            endcase
          end
          CMD_STOP: begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wave_q  <= 1'b0;
          end
          default: ;
        endcase
      end else if (base_tick_i && is_active(state_q)) begin
        // ARMED joins RUN here; this base tick is its first increment.
        state_q <= ST_RUN;
        if (at_term) begin
          count_q <= '0;
          tick_q  <= 1'b1;
          wave_q  <= ~wave_q;
        end else begin
          count_q <= count_q + DIV_W'(1);
        end
      end
    end
  end

  assign tick_o   = tick_q;
  assign wave_o   = wave_q;
  assign active_o = is_active(state_q);

endmodule

// File: rtl/tick_sched.sv
// -----------------------------------------------------------------------------
// tick_sched
// Programmable clock-enable scheduler: one free-running prescaler feeding NCH
// independently configured divider channels, controlled through a valid/ready
// command port.
//
// Optional build macro: TICK_SCHED_PHASE_ALIGN_EN
//   START from IDLE waits for the next base tick, keeping channels started at
//   different times aligned to the prescaler.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   cfg    command port (tick_sched_if slave)
//   S      mute: forces L low, counters keep running
//   tick   per-channel one-cycle enable
//   L      per-channel square wave, masked by S
//   busy   any channel active
// -----------------------------------------------------------------------------
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int PRE_W   = PRE_W_DEF,
  parameter int PRE_MAX = PRE_MAX_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  tick_sched_if.slave    cfg,
  input  logic           S,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] L,
  output logic           busy
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_MAX);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             base_tick;

  logic             ready_q;
  logic             err_q;
  logic             accept;
  logic             ch_ok;

  logic [NCH-1:0]   cmd_stb;
  logic [NCH-1:0]   wave;
  logic [NCH-1:0]   active;

  // Prescaler: free-running, independent of channel state.
  assign base_tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = base_tick ? '0 : pre_q + PRE_W'(1);
  end

  // Ready drops for the cycle after each accept, so a held valid is taken
  // at most every other clock.
  assign accept = cfg.cfg_valid && ready_q;
  assign ch_ok  = ({1'b0, cfg.cfg_ch} < 3'(NCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      ready_q <= ~accept;
      err_q   <= accept && !ch_ok;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    // Out-of-range indices never match a channel, so they change nothing.
    assign cmd_stb[gi] = accept && (cfg.cfg_ch == 2'(gi));

    tick_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .base_tick_i (base_tick),
      .cmd_stb_i   (cmd_stb[gi]),
      .cmd_i       (cfg.cfg_cmd),
      .div_i       (cfg.cfg_div),
      .tick_o      (tick[gi]),
      .wave_o      (wave[gi]),
      .active_o    (active[gi])
    );
  end

  assign L    = S ? '0 : wave;
  assign busy = |active;

endmodule

// File: tb/tb_tick_sched.sv
module tb_tick_sched;
  import tick_sched_pkg::*;

  localparam int NCH     = 2;
  localparam int PRE_W   = 26;
  localparam int PRE_MAX = 3;
  localparam int DIV_W   = 8;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           S     = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] L;
  logic           busy;

  tick_sched_if #(.DIV_W(DIV_W)) cfg_if ();

  tick_sched #(
    .NCH     (NCH),
    .PRE_W   (PRE_W),
    .PRE_MAX (PRE_MAX),
    .DIV_W   (DIV_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg_if),
    .S     (S),
    .tick  (tick),
    .L     (L),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: value the DUT prescaler holds between edges.
  int pre_m;
  always @(posedge clk or posedge reset) begin
    if (reset) pre_m <= 0;
    else       pre_m <= (pre_m == PRE_MAX) ? 0 : pre_m + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pre(input int k);
    int g;
    g = 0;
    while (pre_m != k && g < 8) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Issue one command at the current negedge; returns one negedge after the
  // ready-low cycle, with samples taken right after the accepting edge.
  task automatic cmd(input logic [1:0] ch, input logic [1:0] op, input logic [DIV_W-1:0] dv,
                     output logic err1, output logic rdy1, output logic [NCH-1:0] tk1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_cmd   = op;
    cfg_if.cfg_div   = dv;
    @(negedge clk);
    err1 = cfg_if.cfg_err;
    rdy1 = cfg_if.cfg_ready;
    tk1  = tick;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  // Negedges until tick[ch] is seen high; -1 if the bound expires.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick[ch] !== 1'b1 && n < 64);
    if (tick[ch] !== 1'b1) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic           e, r;
    logic [NCH-1:0] tk;
    int             n;
    int             cnt;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_cmd   = '0;
    cfg_if.cfg_div   = '0;

    // Reset for 20 time units, released at a negedge.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("rst_tick",  32'(tick), 32'd0);
    chk("rst_L",     32'(L), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_err",   32'(cfg_if.cfg_err), 32'd0);

    // ch0 div=3: tick every 12 clk, wave period 24 clk.
    wait_pre(0);
    cmd(2'd0, CMD_SET_DIV, 8'd3, e, r, tk);
    chk("acc_ready_low", 32'(r), 32'd0);
    chk("acc_no_err",    32'(e), 32'd0);
    cmd(2'd0, CMD_START, 8'd0, e, r, tk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_tick", 32'(tick), 32'd0);
    wait_tick(0, n);
    chk("ch0_first_tick", 32'(n), 32'd8);
    chk("ch0_L_high",     32'(L[0]), 32'd1);
    chk("ch1_quiet",      32'(tick[1]), 32'd0);
    wait_tick(0, n);
    chk("ch0_period",  32'(n), 32'd12);
    chk("ch0_L_low",   32'(L[0]), 32'd0);
    step(1);
    chk("ch0_pulse_w", 32'(tick[0]), 32'd0);
    wait_tick(0, n);
    chk("ch0_period2", 32'(n), 32'd11);
    chk("ch0_L_high2", 32'(L), 32'd1);

    // ch1 div=0 behaves as 1: tick every base tick.
    cmd(2'd1, CMD_SET_DIV, 8'd0, e, r, tk);
    cmd(2'd1, CMD_START, 8'd0, e, r, tk);
    chk("ch1_first_tick", 32'(tick), 32'b10);
    chk("ch1_L",          32'(L), 32'b11);
    wait_tick(1, n);
    chk("ch1_period", 32'(n), 32'd4);
    chk("ch1_L_tog",  32'(L), 32'b01);
    S = 1'b1;
    step(1);
    chk("mute_L", 32'(L), 32'd0);
    wait_tick(1, n);
    chk("mute_tick_runs", 32'(n), 32'd3);
    chk("mute_both_tick", 32'(tick), 32'b11);
    chk("mute_L2",        32'(L), 32'd0);
    S = 1'b0;
    step(1);
    chk("unmute_phase", 32'(L), 32'b10);

    // Stop ch1, pause ch0 one base tick into its period, resume later.
    cmd(2'd1, CMD_STOP, 8'd0, e, r, tk);
    chk("stop1_L",    32'(L), 32'd0);
    chk("stop1_busy", 32'(busy), 32'd1);
    step(1);
    cmd(2'd0, CMD_PAUSE, 8'd0, e, r, tk);
    chk("pause_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (42) begin
      @(negedge clk);
      if (tick !== '0) cnt++;
    end
    chk("pause_no_tick", 32'(cnt), 32'd0);
    chk("pause_L",       32'(L), 32'd0);
    cmd(2'd0, CMD_START, 8'd0, e, r, tk);
    wait_tick(0, n);
    chk("resume_tick", 32'(n), 32'd6);
    chk("resume_only0", 32'(tick), 32'b01);
    chk("resume_L",    32'(L), 32'b01);
    cmd(2'd0, CMD_STOP, 8'd0, e, r, tk);
    chk("stop0_L",    32'(L), 32'd0);
    chk("stop0_busy", 32'(busy), 32'd0);

    // Out-of-range channel: accepted, error pulse, no state change.
    cmd(2'd3, CMD_START, 8'd0, e, r, tk);
    chk("bad_ch_err",     32'(e), 32'd1);
    chk("bad_ch_ready",   32'(r), 32'd0);
    chk("bad_ch_err_end", 32'(cfg_if.cfg_err), 32'd0);
    chk("bad_ch_busy",    32'(busy), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd2;
    cfg_if.cfg_cmd   = CMD_START;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (cfg_if.cfg_err === 1'b1) cnt++;
    end
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    if (cfg_if.cfg_err === 1'b1) cnt++;
    chk("held_valid_accepts", 32'(cnt), 32'd2);
    chk("held_ready_back",    32'(cfg_if.cfg_ready), 32'd1);
    chk("held_busy",          32'(busy), 32'd0);

    // Command on the base-tick edge drops that tick for its channel only.
    cmd(2'd0, CMD_SET_DIV, 8'd1, e, r, tk);
    cmd(2'd0, CMD_START, 8'd0, e, r, tk);
    cmd(2'd1, CMD_START, 8'd0, e, r, tk);
    wait_pre(PRE_MAX);
    cmd(2'd0, CMD_SET_DIV, 8'd1, e, r, tk);
    chk("collide0_tick", 32'(tk), 32'b10);
    wait_tick(0, n);
    chk("collide0_next", 32'(n), 32'd3);
    chk("collide0_both", 32'(tick), 32'b11);
    wait_pre(PRE_MAX);
    cmd(2'd1, CMD_PAUSE, 8'd0, e, r, tk);
    chk("collide1_tick", 32'(tk), 32'b01);
    chk("collide1_busy", 32'(busy), 32'd1);

    // Reset while a tick is on the outputs.
    wait_tick(0, n);
    chk("pre_reset_tick", 32'(n), 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_tick",  32'(tick), 32'd0);
    chk("mid_rst_L",     32'(L), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick !== '0 || L !== '0 || busy !== 1'b0) cnt++;
    end
    chk("post_rst_idle", 32'(cnt), 32'd0);
    cmd(2'd0, CMD_START, 8'd0, e, r, tk);
    wait_tick(0, n);
    chk("post_rst_start", 32'(n), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
